alien_formation_motion: RTL and testbench

ALIEN_FORMATION_MOTION -- requirements
Module: alien_formation_motion

---
 rtl/alien_pkg.sv | 20 ++
 rtl/step_divider.sv | 32 +++
 rtl/alien_formation_motion.sv | 135 +++++++++++++
 tb/tb_alien_formation_motion.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alien_pkg.sv
// rtl/alien_pkg.sv - shared formation state encoding and motion step codes
package alien_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RIGHT,
        ST_LEFT,
        ST_DOWN,
        ST_LANDED
    } alien_state_e;

    // One-hot step codes, also decoded by the alien renderer
    typedef enum logic [2:0] {
        MOT_NONE  = 3'b000,
        MOT_RIGHT = 3'b100,
        MOT_DOWN  = 3'b010,
        MOT_LEFT  = 3'b001
    } motion_e;

endpackage

// File: rtl/step_divider.sv
// rtl/step_divider.sv - frame counter producing one step per period of frame ticks
module step_divider #(
    parameter int PERIOD_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                freeze,
    input  logic [PERIOD_W-1:0] period,
    output logic                step
);

    logic [PERIOD_W-1:0] r_frame_cnt;
    logic [PERIOD_W-1:0] w_limit;
    logic                w_run;

    // A period of 0 behaves as 1; >= lets a shrunken period fire at once
    assign w_limit = (period == '0) ? '0 : period - 1'b1;
    assign w_run   = enable & ~freeze;
    assign step    = w_run & (r_frame_cnt >= w_limit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= '0;
        end else if (step) begin
            r_frame_cnt <= '0;
        end else if (w_run) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alien_formation_motion.sv
// rtl/alien_formation_motion.sv - formation march controller: sideways sweeps, edge descents, landing
module alien_formation_motion
    import alien_pkg::*;
#(
    parameter int PERIOD_W     = 6,
    parameter int DOWN_ROWS    = 1,
    parameter int MAX_DESCENTS = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                freeze,
    input  logic                canLeft,
    input  logic                canRight,
    input  logic [PERIOD_W-1:0] period,
    output logic [2:0]          Motion,
    output logic                dir,
    output logic [7:0]          descent_cnt,
    output logic                landed
);

    localparam logic [3:0] ROWS_RELOAD = 4'(DOWN_ROWS - 1);
    localparam logic [7:0] DESC_LIMIT  = 8'(MAX_DESCENTS);

    alien_state_e r_state,  w_state_nxt;
    logic [3:0]   r_rows_left, w_rows_nxt;
    logic         r_dir, w_dir_nxt;
    logic [7:0]   r_descent_cnt, w_desc_nxt, w_desc_inc;
    logic [2:0]   r_motion, w_motion_nxt;
    logic         r_landed;
    logic         w_step;
    logic         w_head_ok, w_back_ok;

    // Landing also stops the frame counter
    step_divider #(.PERIOD_W(PERIOD_W)) u_div (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .freeze (freeze | r_landed),
        .period (period),
        .step   (w_step)
    );

    assign w_desc_inc = r_descent_cnt + 8'd1;
    assign w_head_ok  = r_dir ? canRight : canLeft;
    assign w_back_ok  = r_dir ? canLeft  : canRight;

    always_comb begin
        w_state_nxt  = r_state;
        w_rows_nxt   = r_rows_left;
        w_dir_nxt    = r_dir;
        w_desc_nxt   = r_descent_cnt;
        w_motion_nxt = MOT_NONE;
        if (w_step) begin
            case (r_state)
                ST_IDLE: begin
                    if (canRight) begin
                        w_state_nxt  = ST_RIGHT;
                        w_dir_nxt    = 1'b1;
                        w_motion_nxt = MOT_RIGHT;
                    end else if (canLeft) begin
                        w_state_nxt  = ST_LEFT;
                        w_dir_nxt    = 1'b0;
                        w_motion_nxt = MOT_LEFT;
                    end
                end
                ST_RIGHT: begin
                    if (canRight) begin
                        w_motion_nxt = MOT_RIGHT;
                    end else begin
                        w_state_nxt  = ST_DOWN;
                        w_rows_nxt   = ROWS_RELOAD;
                        w_dir_nxt    = 1'b0;
                        w_motion_nxt = MOT_DOWN;
                    end
                end
                ST_LEFT: begin
                    if (canLeft) begin
                        w_motion_nxt = MOT_LEFT;
                    end else begin
                        w_state_nxt  = ST_DOWN;
                        w_rows_nxt   = ROWS_RELOAD;
                        w_dir_nxt    = 1'b1;
                        w_motion_nxt = MOT_DOWN;
                    end
                end
                ST_DOWN: begin
                    if (r_rows_left != 4'd0) begin
                        w_rows_nxt   = r_rows_left - 4'd1;
                        w_motion_nxt = MOT_DOWN;
                    end else begin
                        w_desc_nxt = w_desc_inc;
                        if (w_desc_inc == DESC_LIMIT) begin
                            w_state_nxt = ST_LANDED;
                        end else if (w_head_ok) begin
                            w_state_nxt  = r_dir ? ST_RIGHT : ST_LEFT;
                            w_motion_nxt = r_dir ? MOT_RIGHT : MOT_LEFT;
                        end else if (w_back_ok) begin
                            w_state_nxt  = r_dir ? ST_LEFT : ST_RIGHT;
                            w_motion_nxt = r_dir ? MOT_LEFT : MOT_RIGHT;
                            w_dir_nxt    = ~r_dir;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_rows_left   <= 4'd0;
            r_dir         <= 1'b1;
            r_descent_cnt <= 8'd0;
            r_motion      <= MOT_NONE;
            r_landed      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rows_left   <= w_rows_nxt;
            r_dir         <= w_dir_nxt;
            r_descent_cnt <= w_desc_nxt;
            r_motion      <= w_motion_nxt;
            r_landed      <= (w_state_nxt == ST_LANDED);
        end
    end

    assign Motion      = r_motion;
    assign dir         = r_dir;
    assign descent_cnt = r_descent_cnt;
    assign landed      = r_landed;

endmodule

// File: tb/tb_alien_formation_motion.sv
// tb/tb_alien_formation_motion.sv - directed and randomized checks of the formation controller
module tb_alien_formation_motion;

    localparam int PW    = 6;
    localparam int ROWS  = 2;
    localparam int MAXD  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          freeze = 1'b0;
    logic          canLeft = 1'b0;
    logic          canRight = 1'b0;
    logic [PW-1:0] period = '0;
    logic [2:0]    Motion;
    logic          dir;
    logic [7:0]    descent_cnt;
    logic          landed;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    alien_formation_motion #(
        .PERIOD_W     (PW),
        .DOWN_ROWS    (ROWS),
        .MAX_DESCENTS (MAXD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .freeze      (freeze),
        .canLeft     (canLeft),
        .canRight    (canRight),
        .period      (period),
        .Motion      (Motion),
        .dir         (dir),
        .descent_cnt (descent_cnt),
        .landed      (landed)
    );

    always #5 clk = ~clk;

    task automatic cmp(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: formation heading (+1/-1), whether it is marching, descending, and counts
    int         m_frame = 0;
    int         m_desc = 0;
    int         m_rows = 0;
    int         m_head = 1;
    bit         m_moving = 0;
    bit         m_descending = 0;
    bit         m_landed = 0;
    logic [2:0] m_motion = 3'b000;

    function automatic logic [2:0] code_of(int h);
        return (h > 0) ? 3'b100 : 3'b001;
    endfunction

    function automatic bit may_go(int h);
        return (h > 0) ? canRight : canLeft;
    endfunction

    task automatic model_step();
        if (m_descending) begin
            if (m_rows > 0) begin
                m_rows--;
                m_motion = 3'b010;
            end else begin
                m_descending = 0;
                m_desc++;
                if (m_desc == MAXD) begin
                    m_landed = 1;
                    m_moving = 0;
                end else if (may_go(m_head)) begin
                    m_moving = 1;
                    m_motion = code_of(m_head);
                end else if (may_go(-m_head)) begin
                    m_head   = -m_head;
                    m_moving = 1;
                    m_motion = code_of(m_head);
                end else begin
                    m_moving = 0;
                end
            end
        end else if (m_moving) begin
            if (may_go(m_head)) begin
                m_motion = code_of(m_head);
            end else begin
                m_descending = 1;
                m_moving     = 0;
                m_rows       = ROWS - 1;
                m_head       = -m_head;
                m_motion     = 3'b010;
            end
        end else if (canRight || canLeft) begin
            m_head   = canRight ? 1 : -1;
            m_moving = 1;
            m_motion = code_of(m_head);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_frame = 0; m_desc = 0; m_rows = 0; m_head = 1;
            m_moving = 0; m_descending = 0; m_landed = 0; m_motion = 3'b000;
        end else begin
            m_motion = 3'b000;
            if (enable && !freeze && !m_landed) begin
                if (m_frame >= ((period == '0) ? 0 : int'(period) - 1)) begin
                    m_frame = 0;
                    model_step();
                end else begin
                    m_frame++;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp("model_motion", int'(Motion), int'(m_motion));
            cmp("model_dir", int'(dir), (m_head > 0) ? 1 : 0);
            cmp("model_descent", int'(descent_cnt), m_desc);
            cmp("model_landed", int'(landed), int'(m_landed));
            cmp("model_frame", int'(dut.u_div.r_frame_cnt), m_frame);
        end
    end

    task automatic pulse(output logic [2:0] mot);
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        mot = Motion;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    logic [2:0] mot;
    int         cnt;

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        cmp("rst_motion", int'(Motion), 0);
        cmp("rst_dir", int'(dir), 1);
        cmp("rst_descent", int'(descent_cnt), 0);
        cmp("rst_landed", int'(landed), 0);
        #2 reset = 1'b1;

        // period 0 acts as 1: every enable steps right
        canRight = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse(mot);
            cmp("p0_motion", int'(mot), 4);
            cmp("p0_frame", int'(dut.u_div.r_frame_cnt), 0);
        end
        @(negedge clk);
        cmp("p0_idle_after", int'(Motion), 0);

        period = 6'd4;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            pulse(mot);
            cmp("p4_motion", int'(mot), (i % 4 == 3) ? 4 : 0);
            if (mot == 3'b100) cnt++;
        end
        cmp("p4_count", cnt, 2);

        // Right edge hit with two down rows, then resume leftwards
        period   = 6'd1;
        canRight = 1'b0;
        canLeft  = 1'b1;
        pulse(mot); cmp("edge_down1", int'(mot), 2);
        pulse(mot); cmp("edge_down2", int'(mot), 2);
        pulse(mot); cmp("edge_left", int'(mot), 1);
        cmp("edge_dir", int'(dir), 0);
        cmp("edge_descent", int'(descent_cnt), 1);

        // Second edge hit lands the formation
        canLeft = 1'b0;
        pulse(mot); cmp("land_down1", int'(mot), 2);
        cmp("land_dir", int'(dir), 1);
        pulse(mot); cmp("land_down2", int'(mot), 2);
        pulse(mot); cmp("land_final", int'(mot), 0);
        cmp("land_flag", int'(landed), 1);
        cmp("land_descent", int'(descent_cnt), 2);
        canRight = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse(mot);
            cmp("landed_motion", int'(mot), 0);
        end
        cmp("landed_hold", int'(descent_cnt), 2);

        // Freeze in the middle of a count
        do_reset();
        period = 6'd8;
        for (int i = 0; i < 3; i++) pulse(mot);
        cmp("frz_pre_frame", int'(dut.u_div.r_frame_cnt), 3);
        freeze = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            pulse(mot);
            if (mot != 3'b000) cnt++;
        end
        cmp("frz_pulses", cnt, 0);
        cmp("frz_frame", int'(dut.u_div.r_frame_cnt), 3);
        freeze = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulse(mot);
            cmp("frz_resume_quiet", int'(mot), 0);
        end
        pulse(mot); cmp("frz_resume_step", int'(mot), 4);

        // Shrinking the period below the count fires on the next enable
        for (int i = 0; i < 5; i++) pulse(mot);
        period = 6'd3;
        pulse(mot); cmp("shrink_step", int'(mot), 4);
        cmp("shrink_frame", int'(dut.u_div.r_frame_cnt), 0);

        // Reset in the middle of a descent
        do_reset();
        period = 6'd1;
        pulse(mot); cmp("mid_right", int'(mot), 4);
        canRight = 1'b0;
        pulse(mot); cmp("mid_down", int'(mot), 2);
        #2 reset = 1'b0;
        #1;
        cmp("mid_rst_motion", int'(Motion), 0);
        cmp("mid_rst_dir", int'(dir), 1);
        cmp("mid_rst_descent", int'(descent_cnt), 0);
        cmp("mid_rst_landed", int'(landed), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        canRight = 1'b1;
        pulse(mot); cmp("mid_after_right", int'(mot), 4);

        // Randomized traffic against the reference
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            enable   = $urandom_range(0, 1) == 1;
            freeze   = $urandom_range(0, 7) == 0;
            canLeft  = $urandom_range(0, 3) != 0;
            canRight = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 15) == 0) period = PW'($urandom_range(0, 5));
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b0;
            end else if (!reset) begin
                #2 reset = 1'b1;
            end
        end
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
